// File: rtl/fifo_rd_stream_if.sv
// fifo_rd_stream_if: FIFO read port plus the valid/ready output stream of fifo_rd_stream.
interface fifo_rd_stream_if #(parameter int FIFO_WIDTH = 16);
   logic                  fifo_empty;
   logic [FIFO_WIDTH-1:0] fifo_dout;
   logic                  fifo_rd_en;
   logic                  m_valid;
   logic                  m_ready;
   logic [FIFO_WIDTH-1:0] m_data;
   modport master (input fifo_empty, fifo_dout, m_ready, output fifo_rd_en, m_valid, m_data);
   modport slave (output fifo_empty, fifo_dout, m_ready, input fifo_rd_en, m_valid, m_data);
endinterface

// File: rtl/fifo_rd_stream.sv
// fifo_rd_stream: FIFO reader absorbing one-cycle read latency into a 2-entry valid/ready buffer.
// Optional FIFO_RD_UNDERFLOW_CHK_EN drops words captured under fifo_underflow and sets err_sticky.
module fifo_rd_stream #(
   parameter int FIFO_WIDTH = 16,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 enable,
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
   input  logic                 fifo_underflow,
   output logic                 err_sticky,
`endif
   output logic [CNT_WIDTH-1:0] rd_count,
   output logic                 busy,
   fifo_rd_stream_if.master     bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t                state;
   logic [FIFO_WIDTH-1:0] mem [2];
   logic [1:0]            occ;
   logic                  inflight, rd_ptr, wr_ptr, pop, capture, pending;
   assign pop = bus.m_valid && bus.m_ready;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
   assign capture = inflight && !fifo_underflow;
`else
   assign capture = inflight;
`endif
   assign pending = occ != 2'd0 || inflight;
   assign bus.m_valid = occ != 2'd0;
   assign bus.m_data = bus.m_valid ? mem[rd_ptr] : '0;
   assign busy = state != IDLE;
   // a read is issued only if the buffer slot is guaranteed once the word lands
   assign bus.fifo_rd_en = !rst && enable && !bus.fifo_empty && state != DRAIN &&
                           ({1'b0, occ} + {2'b0, inflight} < 3'd2 + {2'b0, pop});
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state    <= IDLE;
         occ      <= 2'd0;
         inflight <= 1'b0;
         rd_ptr   <= 1'b0;
         wr_ptr   <= 1'b0;
         rd_count <= '0;
         mem[0]   <= '0;
         mem[1]   <= '0;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
         err_sticky <= 1'b0;
`endif
      end else begin
         inflight <= bus.fifo_rd_en;
         occ      <= occ + {1'b0, capture} - {1'b0, pop};
         if (capture) begin
            mem[wr_ptr] <= bus.fifo_dout;
            wr_ptr      <= !wr_ptr;
         end
         if (pop) begin
            rd_ptr   <= !rd_ptr;
            rd_count <= rd_count + 1'b1;
         end
         state <= enable ? RUN : (pending && state != IDLE) ? DRAIN : IDLE;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
         if (inflight && fifo_underflow) err_sticky <= 1'b1;
`endif
      end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb_fifo_rd_stream: scoreboard bench for fifo_rd_stream against a behavioural FIFO model.
module tb_fifo_rd_stream;
   localparam int W = 16, CW = 4;
   logic          clk = 1'b0, rst = 1'b0, enable = 1'b0, m_ready = 1'b0;
   logic [CW-1:0] rd_count;
   logic          busy;
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
   logic          fifo_underflow = 1'b0, err_sticky;
`endif
   fifo_rd_stream_if #(.FIFO_WIDTH(W)) bus ();
   fifo_rd_stream #(.FIFO_WIDTH(W), .CNT_WIDTH(CW)) dut (
      .clk(clk), .rst(rst), .enable(enable),
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
      .fifo_underflow(fifo_underflow), .err_sticky(err_sticky),
`endif
      .rd_count(rd_count), .busy(busy), .bus(bus));
   always #5 clk = ~clk;
   logic [W-1:0] mem [64];
   logic [W-1:0] dout = '0;
   int           wp = 0, rp = 0;
   assign bus.fifo_empty = (rp == wp);
   assign bus.fifo_dout  = dout;
   assign bus.m_ready    = m_ready;
   always @(posedge clk)
      if (bus.fifo_rd_en) begin
         dout <= mem[rp[5:0]];
         rp   <= rp + 1;
      end
   logic [W-1:0]  sb [$];
   logic [CW-1:0] exp_cnt = '0;
   logic [W-1:0]  hold_data = '0;
   logic          hold = 1'b0;
   int vecs = 0, errs = 0, pulses = 0, cyc = 0, first_rd = -1, first_v = -1, last_v = -1, vcount = 0;
   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask
   task automatic load(input logic [W-1:0] w);
      mem[wp[5:0]] = w;
      wp++;
      sb.push_back(w);
   endtask
   task automatic clear_track();
      pulses = 0; first_rd = -1; first_v = -1; last_v = -1; vcount = 0;
   endtask
   // sample mid-cycle, score pops and handshake stability, then step to just past the edge
   task automatic tick();
      @(negedge clk);
      if (hold) begin
         chk("stable_valid", bus.m_valid, 1);
         chk("stable_data", bus.m_data, hold_data);
      end
      hold = !rst && bus.m_valid && !m_ready;
      hold_data = bus.m_data;
      pulses += int'(bus.fifo_rd_en);
      if (first_rd < 0 && bus.fifo_rd_en) first_rd = cyc;
      if (bus.m_valid) begin
         vcount++;
         if (first_v < 0) first_v = cyc;
         last_v = cyc;
      end
      if (!rst && bus.m_valid && m_ready) begin
         chk("sb_has_word", 32'(sb.size() != 0), 1);
         if (sb.size() != 0) chk("data", bus.m_data, sb.pop_front());
         exp_cnt++;
      end
      cyc++;
      @(posedge clk);
      #1;
   endtask
   initial begin
      #1 rst = 1'b1;
      #1;
      chk("rst_valid", bus.m_valid, 0);
      chk("rst_rd_en", bus.fifo_rd_en, 0);
      chk("rst_busy", busy, 0);
      chk("rst_count", rd_count, 0);
      chk("rst_data", bus.m_data, 0);
      repeat (2) tick();
      rst = 1'b0;
      load(16'h1111); load(16'h2222); load(16'h3333);
      enable = 1'b1; m_ready = 1'b1;
      clear_track();
      repeat (8) tick();
      chk("basic_pulses", pulses, 3);
      chk("basic_latency", first_v - first_rd, 2);
      chk("basic_span", last_v - first_v, 2);
      chk("basic_left", sb.size(), 0);
      chk("basic_count", rd_count, exp_cnt);
      m_ready = 1'b0;
      clear_track();
      for (int i = 0; i < 5; i++) load(16'hA000 + 16'(i));
      repeat (6) tick();
      chk("bp_pulses", pulses, 2);
      chk("bp_valid", bus.m_valid, 1);
      chk("bp_head", bus.m_data, sb[0]);
      m_ready = 1'b1;
      clear_track();
      repeat (10) tick();
      chk("bp_pulses_rest", pulses, 3);
      chk("bp_no_big_gap", 32'(last_v - first_v <= 12), 1);
      chk("bp_left", sb.size(), 0);
      chk("bp_count", rd_count, exp_cnt);
      m_ready = 1'b0;
      clear_track();
      for (int i = 0; i < 5; i++) load(16'hB000 + 16'(i));
      repeat (4) tick();
      chk("pre_rst_pulses", pulses, 2);
      chk("pre_rst_valid", bus.m_valid, 1);
      chk("pre_rst_busy", busy, 1);
      rst = 1'b1; hold = 1'b0;
      #1;
      chk("mid_rst_valid", bus.m_valid, 0);
      chk("mid_rst_rd_en", bus.fifo_rd_en, 0);
      chk("mid_rst_count", rd_count, 0);
      chk("mid_rst_busy", busy, 0);
      exp_cnt = '0;
      void'(sb.pop_front());
      void'(sb.pop_front());
      repeat (2) tick();
      rst = 1'b0; m_ready = 1'b1;
      repeat (10) tick();
      chk("post_rst_left", sb.size(), 0);
      chk("post_rst_count", rd_count, exp_cnt);
      m_ready = 1'b0;
      clear_track();
      load(16'hC000); load(16'hC001); load(16'hC002);
      repeat (2) tick();
      chk("drain_pulses", pulses, 2);
      enable = 1'b0;
      pulses = 0;
      tick();
      chk("drain_busy", busy, 1);
      m_ready = 1'b1;
      repeat (6) tick();
      chk("drain_no_rd", pulses, 0);
      chk("drain_left", sb.size(), 1);
      chk("drain_idle", busy, 0);
      enable = 1'b1;
      repeat (4) tick();
      chk("resume_left", sb.size(), 0);
      clear_track();
      repeat (10) tick();
      chk("empty_rd_en", pulses, 0);
      chk("empty_valid", vcount, 0);
      rst = 1'b1; hold = 1'b0;
      tick();
      rst = 1'b0;
      exp_cnt = '0;
      for (int i = 0; i < 17; i++) load(16'hD000 + 16'(i));
      for (int i = 0; i < 300 && sb.size() != 0; i++) begin
         m_ready = 1'($urandom_range(0, 1));
         tick();
      end
      m_ready = 1'b1;
      chk("wrap_left", sb.size(), 0);
      chk("wrap_count", rd_count, 1);
      chk("wrap_model", rd_count, exp_cnt);
`ifdef FIFO_RD_UNDERFLOW_CHK_EN
      chk("err_clear", err_sticky, 0);
      load(16'hE000); load(16'hE001); load(16'hE002);
      sb.delete(1);
      for (int i = 0; i < 8; i++) begin
         fifo_underflow = (i == 2);
         tick();
      end
      fifo_underflow = 1'b0;
      chk("uf_left", sb.size(), 0);
      chk("uf_err", err_sticky, 1);
      chk("uf_count", rd_count, exp_cnt);
      repeat (3) tick();
      chk("uf_err_held", err_sticky, 1);
      rst = 1'b1; hold = 1'b0;
      #1;
      chk("uf_err_rst", err_sticky, 0);
      tick();
      rst = 1'b0;
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
Read-side consumer for the team's synchronous FIFO. It issues rd_en against the FIFO's empty flag and absorbs the FIFO's one-cycle read latency with a 2-entry output buffer. It presents the words as a valid/ready stream to downstream logic, with no loss, no duplication and no ordering change. It sits between FIFO data_out and any sink that can apply backpressure, and counts delivered words.

Parameters:
FIFO_WIDTH, 16, data width; must equal the FIFO's data width.
CNT_WIDTH, 16, width of the delivered-word counter.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  asynchronous reset, active-high.
enable  in  1  permission to issue new FIFO reads.
fifo_empty  in  1  FIFO empty flag.
fifo_dout  in  FIFO_WIDTH  FIFO data_out; valid the cycle after fifo_rd_en.
fifo_rd_en  out  1  read strobe to FIFO.
m_valid  out  1  output word available.
m_ready  in  1  sink accepts the word.
m_data  out  FIFO_WIDTH  oldest buffered word.
rd_count  out  CNT_WIDTH  number of completed m_valid&&m_ready transfers.
busy  out  1  high in RUN or DRAIN state.

Behaviour:
- Reset (async, rst=1): buffer occupancy = 0, in-flight flag = 0, FSM = IDLE, rd_count = 0. Outputs fifo_rd_en = 0, m_valid = 0, m_data = 0, busy = 0. These take effect immediately, not at the next edge.
- Reset mid-operation: any in-flight word and all buffered words are discarded. Nothing is captured on the first edge after rst falls.
- Internal state: occ (0..2), inflight (1 bit = fifo_rd_en registered), 2-entry circular buffer with rd_ptr and wr_ptr.
- pop = m_valid && m_ready. m_valid = (occ != 0). m_data = buf[rd_ptr] (0 when occ = 0).
- fifo_rd_en is combinational: enable && !fifo_empty && state != DRAIN && (occ + inflight - pop) < 2. It never over-commits the buffer, and gives full throughput when m_ready is held high.
- Capture: when inflight = 1, fifo_dout is written to buf[wr_ptr] at the clock edge.
- occ update: next occ = occ + capture - pop. Simultaneous capture and pop leaves occ unchanged, with the pointers each advancing by 1 mod 2.
- Latency: fifo_rd_en high in cycle N → word is on m_data with m_valid = 1 in cycle N+2.
- Streaming: continuous m_ready = 1 with a non-empty FIFO → one word per cycle.
- Handshake rules:
  - m_data and m_valid stay stable while m_valid && !m_ready.
  - m_valid never drops without a pop.
- rd_count increments on every pop and wraps modulo 2^CNT_WIDTH.
- FSM:
  - IDLE: enable=1 → RUN.
  - RUN: enable=0 with (occ != 0 or inflight = 1) → DRAIN. enable=0 with nothing pending → IDLE.
  - DRAIN: no new reads; buffered and in-flight words are still delivered. When occ = 0, inflight = 0 and no capture is pending → IDLE. enable=1 → RUN.
- busy = (state != IDLE).
- fifo_empty=1 → fifo_rd_en held 0. Words already in flight are still captured.

Optional Feature:
Macro FIFO_RD_UNDERFLOW_CHK_EN.
- Defined:
  - Adds input fifo_underflow (1 bit, the FIFO's underflow flag) and output err_sticky (1 bit, reset 0).
  - On a capture cycle with fifo_underflow=1, the word is discarded: occ and wr_ptr are unchanged, and err_sticky is set to 1 and held until rst.
  - A capture cycle with fifo_underflow=0 behaves normally.
- Undefined: both ports are absent, and every in-flight word is captured unconditionally.

Test Plan:
- Reset mid-stream: assert rst with occ=2 and m_valid=1 → m_valid, fifo_rd_en, rd_count and busy go to 0 in the same cycle. After release, no stale word appears.
- Basic stream (FIFO_WIDTH=16): FIFO holds 0x1111, 0x2222, 0x3333; enable=1, m_ready=1 → fifo_rd_en high for 3 consecutive cycles. m_data shows 0x1111, 0x2222, 0x3333 on consecutive cycles starting 2 cycles after the first fifo_rd_en. Ends with rd_count=3.
- Backpressure: FIFO holds 5 words, m_ready=0 → exactly 2 fifo_rd_en pulses, then 0. m_valid=1 with m_data=word0 held stable. Raise m_ready → all 5 words delivered in order with no gaps beyond 2 cycles. Ends with rd_count=5.
- Drain: drop enable one cycle after a fifo_rd_en with occ=1 → FSM enters DRAIN, no further fifo_rd_en, 2 words delivered, then busy=0 and FSM returns to IDLE.
- Empty and wrap: fifo_empty=1 for 10 cycles → fifo_rd_en=0 and m_valid=0 throughout. Then with CNT_WIDTH=4, deliver 17 words → rd_count=1.
- FIFO_RD_UNDERFLOW_CHK_EN defined: force fifo_underflow=1 on the capture cycle of word 2 of 3 → only words 1 and 3 are delivered, err_sticky=1 and held until rst.
